// File: rtl/conv_pixel_sched.sv
// ============================================================================
// Module   : conv_pixel_sched
// Purpose  : Per-window scheduler for a CIM convolution layer: loads the
//            input words, fires the CIM, hands the pixel to the output stage
//            and walks the padded window origin across the image.
//            Optional busy-cycle counter: CONV_PIXEL_SCHED_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_pixel_sched #(
    parameter int DATA_SIZE      = 8,
    parameter int IMG_DIM        = 28,
    parameter int KERNEL_DIM     = 3,
    parameter int STRIDE         = 1,
    parameter int PADDING        = 0,
    parameter int INPUT_CHANNELS = 2,
    parameter int XBAR_SIZE      = 128,
    parameter int BUS_WIDTH      = 16,
    localparam int V_CIM_TILES   = (INPUT_CHANNELS*KERNEL_DIM*KERNEL_DIM + XBAR_SIZE - 1) / XBAR_SIZE,
    localparam int NUM_ADDR      = (INPUT_CHANNELS*KERNEL_DIM*KERNEL_DIM + BUS_WIDTH*V_CIM_TILES - 1)
                                   / (BUS_WIDTH*V_CIM_TILES),
    localparam int ADDR_WIDTH    = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1,
    localparam int OUT_DIM       = (IMG_DIM + 2*PADDING - KERNEL_DIM) / STRIDE + 1,
    localparam int CW            = $clog2(IMG_DIM + 2*PADDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    output logic                  o_ready,
    output logic [CW-1:0]         o_win_row,
    output logic [CW-1:0]         o_win_col,
    output logic                  o_pad,
    output logic [ADDR_WIDTH-1:0] o_ibuf_addr,
    output logic                  o_cim_we,
    output logic                  o_cim_start,
    input  logic                  i_cim_ready,
    output logic                  o_func_start,
    input  logic                  i_func_ready,
    output logic                  o_frame_done
`ifdef CONV_PIXEL_SCHED_PERF_EN
    ,
    output logic [31:0]           o_busy_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        START    = 3'd2,
        WAIT_CIM = 3'd3,
        FUNC     = 3'd4,
        ADVANCE  = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic [CW-1:0]         c_pad       = CW'(PADDING);
    localparam logic [CW-1:0]         c_kern      = CW'(KERNEL_DIM);
    localparam logic [CW-1:0]         c_far       = CW'(IMG_DIM + PADDING);
    localparam logic [CW-1:0]         c_stride    = CW'(STRIDE);
    localparam logic [CW-1:0]         c_last_pos  = CW'((OUT_DIM - 1) * STRIDE);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(NUM_ADDR - 1);

    generate
        if (STRIDE < 1 || DATA_SIZE < 1) begin : g_bad_params
            $error("conv_pixel_sched: STRIDE and DATA_SIZE must be at least 1");
        end
    endgenerate

    state_t                  state_q, state_d;
    logic [CW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    w_pad_lo;
    logic                    w_pad_hi;
    logic                    w_in_window;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        addr_d       = addr_q;
        o_cim_we     = 1'b0;
        o_cim_start  = 1'b0;
        o_func_start = 1'b0;
        o_frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = LOAD;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                end
            end
            LOAD: begin
                o_cim_we = 1'b1;
                if (addr_q == c_last_addr) begin
                    addr_d  = '0;
                    state_d = START;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            START: begin
                o_cim_start = 1'b1;
                state_d     = WAIT_CIM;
            end
            WAIT_CIM: begin
                if (i_cim_ready) begin
                    state_d = FUNC;
                end
            end
            FUNC: begin
                o_func_start = i_func_ready;
                if (i_func_ready) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                // Origin wraps to (0,0) after the last window so it never exceeds the last position.
                if (col_q == c_last_pos) begin
                    col_d = '0;
                    if (row_q == c_last_pos) begin
                        row_d   = '0;
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + c_stride;
                        state_d = LOAD;
                    end
                end else begin
                    col_d   = col_q + c_stride;
                    state_d = LOAD;
                end
            end
            DONE: begin
                o_frame_done = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    generate
        if (PADDING > 0) begin : g_pad_lo
            assign w_pad_lo = (row_q < c_pad) || (col_q < c_pad);
        end else begin : g_no_pad_lo
            assign w_pad_lo = 1'b0;
        end
    endgenerate

    assign w_pad_hi    = ((row_q + c_kern) > c_far) || ((col_q + c_kern) > c_far);
    // Padding flag only describes a live window; IDLE and DONE report 0.
    assign w_in_window = (state_q != IDLE) && (state_q != DONE);
    assign o_pad       = w_in_window && (w_pad_lo || w_pad_hi);

    assign o_ready     = (state_q == IDLE);
    assign o_win_row   = row_q;
    assign o_win_col   = col_q;
    assign o_ibuf_addr = (state_q == LOAD) ? addr_q : '0;

`ifdef CONV_PIXEL_SCHED_PERF_EN
    logic [31:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (state_q == IDLE) begin
            if (i_start) begin
                busy_d = '0;
            end
        end else if (busy_q != 32'hFFFF_FFFF) begin
            busy_d = busy_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_busy_cycles = busy_q;
`endif

endmodule

`default_nettype wire

// File: doc/conv_pixel_sched.md
CONV_PIXEL_SCHED -- requirements
Module: conv_pixel_sched

Interface
REQ-001 Parameter DATA_SIZE, default 8: activation bit width; informational, sets no widths.
REQ-002 Parameter IMG_DIM, default 28: unpadded square input image side.
REQ-003 Parameter KERNEL_DIM, default 3: square kernel side.
REQ-004 Parameter STRIDE, default 1: window step, legal range 1 or more.
REQ-005 Parameter PADDING, default 0: zero border width on each side.
REQ-006 Parameter INPUT_CHANNELS, default 2; XBAR_SIZE, default 128; BUS_WIDTH, default 16.
REQ-007 Derived values:
- V_CIM_TILES = ceil(INPUT_CHANNELS*KERNEL_DIM^2/XBAR_SIZE).
- NUM_ADDR = ceil(INPUT_CHANNELS*KERNEL_DIM^2/(BUS_WIDTH*V_CIM_TILES)), integer ceil.
- ADDR_WIDTH = max(1, clog2(NUM_ADDR)).
- OUT_DIM = floor((IMG_DIM+2*PADDING-KERNEL_DIM)/STRIDE)+1.
- CW = clog2(IMG_DIM+2*PADDING+1).
REQ-008 clk  in  1  sole clock; all state updates on its rising edge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 i_start  in  1  frame start; the input buffer holds a complete image.
REQ-011 o_ready  out  1  high only in IDLE.
REQ-012 o_win_row, o_win_col  out  CW each  padded-coordinate origin of the current window.
REQ-013 o_pad  out  1  current window overlaps the padding border.
REQ-014 o_ibuf_addr  out  ADDR_WIDTH  input-buffer/CIM word address.
REQ-015 o_cim_we  out  1  CIM input write strobe.
REQ-016 o_cim_start  out  1  one-cycle CIM compute pulse.
REQ-017 i_cim_ready  in  1  CIM result available.
REQ-018 o_func_start  out  1  one-cycle output-stage start pulse.
REQ-019 i_func_ready  in  1  output stage can accept a pixel.
REQ-020 o_frame_done  out  1  one-cycle end-of-frame pulse.

Function
REQ-021 FSM states: IDLE, LOAD, START, WAIT_CIM, FUNC, ADVANCE, DONE; all outputs are decoded from registered state and counters.
REQ-022 IDLE: i_start=1 moves to LOAD with the window origin at (0,0); i_start is ignored in every other state.
REQ-023 LOAD: lasts exactly NUM_ADDR cycles.
- o_cim_we=1 throughout.
- o_ibuf_addr steps 0..NUM_ADDR-1, one word per cycle.
- Exits to START.
REQ-024 START: exactly one cycle; o_cim_start=1; exits to WAIT_CIM.
REQ-025 WAIT_CIM: occupies at least one cycle; i_cim_ready is sampled from the first WAIT_CIM cycle; i_cim_ready=1 moves to FUNC.
REQ-026 FUNC: o_func_start = i_func_ready; i_func_ready=1 moves to ADVANCE; i_func_ready=0 holds in FUNC.
REQ-027 ADVANCE, one cycle:
- o_win_col += STRIDE.
- At the last column, o_win_col returns to 0 and o_win_row += STRIDE.
- After window (OUT_DIM-1, OUT_DIM-1) the state moves to DONE; otherwise it moves to LOAD.
REQ-028 DONE: one cycle with o_frame_done=1; then IDLE.
REQ-029 o_pad=1 when win_row<PADDING, win_col<PADDING, win_row+KERNEL_DIM>IMG_DIM+PADDING, or win_col+KERNEL_DIM>IMG_DIM+PADDING.
REQ-030 Minimum latency is NUM_ADDR+4 cycles per window; a frame is OUT_DIM^2*(NUM_ADDR+4)+1 cycles from the first LOAD through DONE.
REQ-031 o_win_row and o_win_col never exceed (OUT_DIM-1)*STRIDE.
REQ-032 o_ibuf_addr is 0 outside LOAD.

Reset
REQ-033 rst=1 forces IDLE immediately, regardless of clk, including mid-frame.
REQ-034 Values while rst=1:
- o_ready=1.
- All counters, o_win_row, o_win_col, o_ibuf_addr and o_pad are 0.
- o_cim_we, o_cim_start, o_func_start and o_frame_done are 0.
REQ-035 After reset, a new frame requires a fresh i_start; there is no partial-frame resume.

Configuration
REQ-036 Macro CONV_PIXEL_SCHED_PERF_EN defined:
- Adds output o_busy_cycles, 32 bits.
- The counter clears on i_start acceptance and increments every non-IDLE cycle.
- It saturates at 2^32-1, holds its value in IDLE, and resets to 0.
REQ-037 Macro undefined: the port and the counter are absent; all other behaviour is identical.

Verification
REQ-038 Basic frame, all ready inputs held at 1:
- Config: IMG_DIM=4, KERNEL_DIM=3, STRIDE=1, PADDING=0, INPUT_CHANNELS=2.
- Stimulus: one i_start pulse.
- Response: four windows at (0,0), (0,1), (1,0), (1,1).
- Each window drives o_ibuf_addr 0,1 with o_cim_we=1 and gives exactly one o_cim_start and one o_func_start.
- o_pad=0 throughout; o_frame_done pulses 25 cycles after i_start.
REQ-039 Padding and stride:
- Config: IMG_DIM=4, KERNEL_DIM=3, STRIDE=2, PADDING=1.
- Response: windows at (0,0), (0,2), (2,0), (2,2).
- o_pad is 1, 1, 1, 0 respectively.
REQ-040 Backpressure: hold i_cim_ready low 5 cycles, then i_func_ready low 3 cycles, in window 2 -> that window grows by exactly 8 cycles; no extra o_cim_start or o_func_start pulses.
REQ-041 Reset mid-frame: assert rst during the WAIT_CIM of window 3 -> outputs reach their reset values without a clock edge, o_ready=1, and no o_frame_done pulse occurs.
REQ-042 i_start pulse during LOAD -> ignored; the frame completes unchanged.
REQ-043 With CONV_PIXEL_SCHED_PERF_EN defined, the REQ-038 frame -> o_busy_cycles=25 in IDLE afterwards, and it clears on the next i_start acceptance.
